// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer sitting beside the execute-stage ALU.
// Ports:
//   clk, rstn_i         clock, async active-low reset
//   valid_i, funct3_i   op request (sampled while ready_o=1) and M-extension funct3
//   rs1_i, rs2_i        operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   flush_i             abort an in-flight op, block accept in IDLE
//   ready_o             1 while IDLE
//   stall_o             combinational pipeline freeze while an op is accepted/in flight
//   valid_o, result_o   one-cycle result strobe, result held until the next strobe or reset
module ex_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;     // MUL: {hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [1:0]        f3_q, f3_d;       // funct3[1:0]; MUL vs DIV is carried by the state
    logic              neg_q, neg_d;     // negate the selected result at DONE entry
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand sign handling at accept
    logic            is_div, sgn1, sgn2, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        is_div = funct3_i[2];
        sgn1   = (funct3_i == 3'b001) || (funct3_i == 3'b010) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sgn2   = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sa     = sgn1 & rs1_i[XLEN-1];
        sb     = sgn2 & rs2_i[XLEN-1];
        a_mag  = sa ? -rs1_i : rs1_i;
        b_mag  = sb ? -rs2_i : rs2_i;
    end

    // One shift-add multiply step and one restoring divide step
    logic [XLEN:0]     mul_sum, div_rsh, div_rem;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_step, div_step, mul_fin;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
        div_rsh  = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = div_rsh >= {1'b0, opnd_q};
        div_rem  = div_ge ? div_rsh - {1'b0, opnd_q} : div_rsh;
        div_step = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
        mul_fin  = neg_q ? -mul_step : mul_step;
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        valid_d  = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    f3_d  = funct3_i[1:0];
                    cnt_d = '0;
                    if (is_div && rs2_i == '0) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = funct3_i[1] ? rs1_i : '1;
                    end else if (is_div && !funct3_i[0] && rs1_i == INT_MIN && rs2_i == '1) begin
                        // Signed overflow: quotient saturates to INT_MIN, remainder is zero
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = funct3_i[1] ? '0 : INT_MIN;
                    end else if (is_div) begin
                        state_d = S_DIV;
                        opnd_d  = b_mag;
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        neg_d   = funct3_i[1] ? sa : (sa ^ sb);
                    end else begin
                        state_d = S_MUL;
                        opnd_d  = a_mag;
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        neg_d   = sa ^ sb;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = (state_q == S_MUL) ? mul_step : div_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        if (state_q == S_MUL) begin
                            result_d = (f3_q == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
                        end else if (f3_q[1]) begin
                            result_d = neg_q ? -div_step[2*XLEN-1:XLEN] : div_step[2*XLEN-1:XLEN];
                        end else begin
                            result_d = neg_q ? -div_step[XLEN-1:0] : div_step[XLEN-1:0];
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    // stall is gated by reset so a request held across reset does not freeze the pipe
    assign ready_o  = (state_q == S_IDLE);
    assign stall_o  = rstn_i & (((state_q == S_IDLE) & valid_i & ~flush_i) |
                                (state_q == S_MUL) | (state_q == S_DIV));
    assign valid_o  = valid_q;
    assign result_o = result_q;

    // Iteration counter must never pass the last iteration
    cnt_bound_a: assert property (@(posedge clk) disable iff (!rstn_i) cnt_q <= CNT_LAST);

endmodule
